// File: rtl/plic_defs.sv
// ---------------------------------------------------------------------------
// plic_defs
// Shared constants for the PLIC interrupt front end.
//   PLIC_SOURCE_COUNT    : number of external interrupt sources conditioned
//   PLIC_IRQ_SYNC_STAGES : synchronizer depth per source (legal 2..4)
//   PLIC_IRQ_FILT_WIDTH  : width of the debounce threshold and counter
// ---------------------------------------------------------------------------
package plic_defs;

   localparam int PLIC_SOURCE_COUNT    = 8;
   localparam int PLIC_IRQ_SYNC_STAGES = 2;
   localparam int PLIC_IRQ_FILT_WIDTH  = 4;

endpackage : plic_defs

// File: rtl/plic_irq_filter.sv
// ---------------------------------------------------------------------------
// plic_irq_filter
// Conditions one raw asynchronous interrupt line: synchronizer chain,
// polarity inversion, then a debounce filter that only accepts a new level
// once it has differed from the current one for L consecutive cycles.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   raw_i          : raw asynchronous interrupt line
//   polarity_i     : 1 = line is active-low
//   filt_en_i      : 1 = debounce enabled
//   filt_len_i     : debounce threshold in cycles (0 behaves as 1)
//   glitch_clr_i   : clears the sticky glitch flag
//   level_o        : conditioned active-high level
//   rise_o         : one-cycle pulse in the first cycle level_o reads 1
//   glitch_o       : sticky flag, a shorter-than-threshold excursion was seen
// ---------------------------------------------------------------------------
module plic_irq_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  raw_i,
   input  logic                  polarity_i,
   input  logic                  filt_en_i,
   input  logic [FILT_WIDTH-1:0] filt_len_i,
   input  logic                  glitch_clr_i,
   output logic                  level_o,
   output logic                  rise_o,
   output logic                  glitch_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   stable_q, stable_d;
   logic [FILT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                   glitch_q, glitch_d;
   logic                   rise_q, rise_d;
   logic                   sample;
   logic [FILT_WIDTH-1:0]  thrMinus1;

   // The synchronizer shifts the raw line in at bit 0; the oldest (most
   // settled) copy sits at the top of the chain. Every stage resets to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   // Polarity is applied after synchronization, so a polarity flip looks
   // like an ordinary input change and goes through the filter as well.
   assign sample = sync_q[SYNC_STAGES-1] ^ polarity_i;

   // The accept test compares against L-1 where L is the effective
   // threshold. A disabled filter or a zero length both mean L = 1, so any
   // difference is taken on the very next edge.
   always_comb begin
      thrMinus1 = '0;
      if (filt_en_i && (filt_len_i != '0)) begin
         thrMinus1 = filt_len_i - FILT_WIDTH'(1);
      end
   end

   // Debounce decision. Using >= means a threshold lowered mid-count is
   // honoured on the next differing cycle. A return to the stable level with
   // a non-zero count is a rejected excursion and raises the sticky flag;
   // raising the flag wins over a simultaneous clear request.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      glitch_d = glitch_q;
      if (sample != stable_q) begin
         if (cnt_q >= thrMinus1) begin
            stable_d = sample;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + FILT_WIDTH'(1);
         end
         if (glitch_clr_i) begin
            glitch_d = 1'b0;
         end
      end else begin
         cnt_d = '0;
         if (cnt_q != '0) begin
            glitch_d = 1'b1;
         end else if (glitch_clr_i) begin
            glitch_d = 1'b0;
         end
      end
      rise_d = stable_d & ~stable_q;
   end

   // Filter state registers; the rise pulse is registered so it lines up
   // with the first cycle the new level is visible on level_o.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         glitch_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         glitch_q <= glitch_d;
         rise_q   <= rise_d;
      end
   end

   assign level_o  = stable_q;
   assign rise_o   = rise_q;
   assign glitch_o = glitch_q;

endmodule : plic_irq_filter

// File: rtl/plic_irq_conditioner.sv
// ---------------------------------------------------------------------------
// plic_irq_conditioner
// Upstream conditioning stage for the PLIC. Each source is handled by an
// independent plic_irq_filter; only the debounce length is shared.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   irq_raw_i      : raw asynchronous interrupt lines
//   polarity_i     : per-source 1 = active-low
//   filt_en_i      : per-source debounce enable
//   filt_len_i     : shared debounce threshold (0 behaves as 1)
//   glitch_clr_i   : per-source clear of the sticky glitch flag
//   irq_src_o      : conditioned active-high levels to the PLIC
//   irq_rise_o     : one-cycle rising-edge pulses
//   glitch_o       : sticky glitch-rejected flags
// ---------------------------------------------------------------------------
module plic_irq_conditioner
   import plic_defs::*;
#(
   parameter int NUM_SRC     = PLIC_SOURCE_COUNT,
   parameter int SYNC_STAGES = PLIC_IRQ_SYNC_STAGES,
   parameter int FILT_WIDTH  = PLIC_IRQ_FILT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC-1:0]    irq_raw_i,
   input  logic [NUM_SRC-1:0]    polarity_i,
   input  logic [NUM_SRC-1:0]    filt_en_i,
   input  logic [FILT_WIDTH-1:0] filt_len_i,
   input  logic [NUM_SRC-1:0]    glitch_clr_i,
   output logic [NUM_SRC-1:0]    irq_src_o,
   output logic [NUM_SRC-1:0]    irq_rise_o,
   output logic [NUM_SRC-1:0]    glitch_o
);

   // One filter per source; there is no interaction between sources.
   for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
      plic_irq_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_WIDTH  (FILT_WIDTH)
      ) uFilter (
         .clk          (clk),
         .rst_n        (rst_n),
         .raw_i        (irq_raw_i[i]),
         .polarity_i   (polarity_i[i]),
         .filt_en_i    (filt_en_i[i]),
         .filt_len_i   (filt_len_i),
         .glitch_clr_i (glitch_clr_i[i]),
         .level_o      (irq_src_o[i]),
         .rise_o       (irq_rise_o[i]),
         .glitch_o     (glitch_o[i])
      );
   end

endmodule : plic_irq_conditioner

// File: tb/tb_plic_irq_conditioner.sv
// ---------------------------------------------------------------------------
// tb_plic_irq_conditioner
// Directed bench for plic_irq_conditioner with 8 sources, a 2-flop
// synchronizer and a 4-bit debounce counter. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_plic_irq_conditioner;

   localparam int N = 8;
   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] irqRaw;
   logic [N-1:0] polarity;
   logic [N-1:0] filtEn;
   logic [W-1:0] filtLen;
   logic [N-1:0] glitchClr;
   logic [N-1:0] irqSrc;
   logic [N-1:0] irqRise;
   logic [N-1:0] glitch;

   int vecCount;
   int missCount;

   plic_irq_conditioner #(
      .NUM_SRC     (N),
      .SYNC_STAGES (2),
      .FILT_WIDTH  (W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq_raw_i    (irqRaw),
      .polarity_i   (polarity),
      .filt_en_i    (filtEn),
      .filt_len_i   (filtLen),
      .glitch_clr_i (glitchClr),
      .irq_src_o    (irqSrc),
      .irq_rise_o   (irqRise),
      .glitch_o     (glitch)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive the shared input set in one step.
   task automatic applyStimulus(input logic [N-1:0] raw, input logic [N-1:0] pol,
                                input logic [N-1:0] en, input logic [W-1:0] len,
                                input logic [N-1:0] clr);
      irqRaw    = raw;
      polarity  = pol;
      filtEn    = en;
      filtLen   = len;
      glitchClr = clr;
   endtask

   // Advance n rising edges, leaving time 1 ns past the last one.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;

      // Reset with every raw line asserted: nothing may leak through.
      rst_n = 1'b0;
      applyStimulus('1, 8'h04, '0, 4'd0, '0);
      #1;
      checkOutput("reset src", 32'(irqSrc), 32'h0);
      checkOutput("reset rise", 32'(irqRise), 32'h0);
      checkOutput("reset glitch", 32'(glitch), 32'h0);
      tick(5);
      checkOutput("reset hold src", 32'(irqSrc), 32'h0);
      checkOutput("reset hold rise", 32'(irqRise), 32'h0);
      checkOutput("reset hold glitch", 32'(glitch), 32'h0);

      // Source 2 is active-low and held high (inactive); others idle low.
      applyStimulus(8'h04, 8'h04, '0, 4'd0, '0);
      rst_n = 1'b1;
      tick(10);
      applyStimulus(8'h04, 8'h04, '0, 4'd0, '1);
      tick(1);
      applyStimulus(8'h04, 8'h04, '0, 4'd0, '0);
      tick(1);
      checkOutput("settled src", 32'(irqSrc), 32'h0);
      checkOutput("settled glitch", 32'(glitch), 32'h0);

      // Filter off, source 3: level appears exactly 3 edges after raw rises.
      applyStimulus(8'h0C, 8'h04, '0, 4'd0, '0);
      tick(2);
      checkOutput("nofilt src3 e2", 32'(irqSrc[3]), 32'h0);
      tick(1);
      checkOutput("nofilt src3 e3", 32'(irqSrc[3]), 32'h1);
      checkOutput("nofilt rise3 e3", 32'(irqRise[3]), 32'h1);
      tick(1);
      checkOutput("nofilt rise3 e4", 32'(irqRise[3]), 32'h0);
      checkOutput("nofilt src3 e4", 32'(irqSrc[3]), 32'h1);
      checkOutput("nofilt glitch3", 32'(glitch[3]), 32'h0);
      applyStimulus(8'h04, 8'h04, '0, 4'd0, '0);
      tick(3);
      checkOutput("nofilt src3 fall", 32'(irqSrc[3]), 32'h0);
      checkOutput("nofilt rise3 fall", 32'(irqRise[3]), 32'h0);

      // Filter on (len 5), source 0: a 3-cycle pulse is rejected as a glitch.
      applyStimulus(8'h05, 8'h04, 8'h01, 4'd5, '0);
      tick(3);
      applyStimulus(8'h04, 8'h04, 8'h01, 4'd5, '0);
      tick(3);
      checkOutput("short pulse src0", 32'(irqSrc[0]), 32'h0);
      checkOutput("short pulse glitch0", 32'(glitch[0]), 32'h1);
      tick(3);
      checkOutput("glitch0 sticky", 32'(glitch[0]), 32'h1);
      applyStimulus(8'h04, 8'h04, 8'h01, 4'd5, 8'h01);
      tick(1);
      checkOutput("glitch0 cleared", 32'(glitch[0]), 32'h0);

      // A held assertion on source 0 appears 7 edges after the raw edge.
      applyStimulus(8'h05, 8'h04, 8'h01, 4'd5, '0);
      tick(6);
      checkOutput("long pulse src0 e6", 32'(irqSrc[0]), 32'h0);
      tick(1);
      checkOutput("long pulse src0 e7", 32'(irqSrc[0]), 32'h1);
      checkOutput("long pulse rise0 e7", 32'(irqRise[0]), 32'h1);
      checkOutput("long pulse glitch0", 32'(glitch[0]), 32'h0);
      applyStimulus(8'h04, 8'h04, 8'h01, 4'd5, '0);
      tick(10);
      checkOutput("src0 released", 32'(irqSrc[0]), 32'h0);

      // Source 2 active-low, filter off: raw low asserts, raw high deasserts.
      applyStimulus(8'h00, 8'h04, 8'h01, 4'd5, '0);
      tick(2);
      checkOutput("pol src2 e2", 32'(irqSrc[2]), 32'h0);
      tick(1);
      checkOutput("pol src2 e3", 32'(irqSrc[2]), 32'h1);
      checkOutput("pol rise2 e3", 32'(irqRise[2]), 32'h1);
      applyStimulus(8'h04, 8'h04, 8'h01, 4'd5, '0);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         checkOutput("pol rise2 on fall", 32'(irqRise[2]), 32'h0);
      end
      checkOutput("pol src2 fell", 32'(irqSrc[2]), 32'h0);

      // Source 1 glitch: a set in the same cycle as a clear wins.
      applyStimulus(8'h06, 8'h04, 8'h02, 4'd5, '0);
      tick(3);
      applyStimulus(8'h04, 8'h04, 8'h02, 4'd5, '0);
      tick(3);
      checkOutput("glitch1 first", 32'(glitch[1]), 32'h1);
      tick(4);
      applyStimulus(8'h06, 8'h04, 8'h02, 4'd5, '0);
      tick(3);
      applyStimulus(8'h04, 8'h04, 8'h02, 4'd5, '0);
      tick(2);
      applyStimulus(8'h04, 8'h04, 8'h02, 4'd5, 8'h02);
      tick(1);
      checkOutput("glitch1 set beats clr", 32'(glitch[1]), 32'h1);
      applyStimulus(8'h04, 8'h04, 8'h02, 4'd5, '0);
      tick(2);
      checkOutput("glitch1 quiet", 32'(glitch[1]), 32'h1);
      applyStimulus(8'h04, 8'h04, 8'h02, 4'd5, 8'h02);
      tick(1);
      checkOutput("glitch1 quiet clr", 32'(glitch[1]), 32'h0);
      checkOutput("glitch1 src", 32'(irqSrc[1]), 32'h0);

      // Source 4: len 10 counts to 6, then len drops to 4 and it accepts.
      applyStimulus(8'h14, 8'h04, 8'h10, 4'd10, '0);
      tick(8);
      checkOutput("thresh src4 cnt6", 32'(irqSrc[4]), 32'h0);
      applyStimulus(8'h14, 8'h04, 8'h10, 4'd4, '0);
      tick(1);
      checkOutput("thresh src4 lowered", 32'(irqSrc[4]), 32'h1);
      checkOutput("thresh rise4", 32'(irqRise[4]), 32'h1);
      applyStimulus(8'h04, 8'h04, 8'h10, 4'd4, '0);
      tick(10);
      checkOutput("thresh src4 released", 32'(irqSrc[4]), 32'h0);

      // Source 5: reset mid-count, then the held input re-qualifies.
      applyStimulus(8'h24, 8'h04, 8'h20, 4'd5, '0);
      tick(5);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset src", 32'(irqSrc), 32'h0);
      checkOutput("midreset glitch", 32'(glitch), 32'h0);
      checkOutput("midreset rise", 32'(irqRise), 32'h0);
      #2;
      rst_n = 1'b1;
      tick(6);
      checkOutput("post reset src5 e6", 32'(irqSrc[5]), 32'h0);
      tick(1);
      checkOutput("post reset src5 e7", 32'(irqSrc[5]), 32'h1);
      checkOutput("post reset rise5 e7", 32'(irqRise[5]), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule : tb_plic_irq_conditioner

// File: doc/plic_irq_conditioner.md
Name: plic_irq_conditioner

Overview:
Upstream conditioning stage for the PLIC. It takes raw, asynchronous external interrupt lines and drives the PLIC's irq_src_i.
- Per source: multi-flop synchronizer, programmable polarity, then a glitch/debounce filter.
- Produces clean, registered level outputs, one-cycle rising-edge pulses, and sticky glitch-rejected flags for software diagnostics.

Parameters:
- NUM_SRC, PLIC_SOURCE_COUNT: number of interrupt sources conditioned.
- SYNC_STAGES, 2: synchronizer depth; legal values 2..4.
- FILT_WIDTH, 4: width of the debounce threshold and per-source counter.

Ports:
- rst_n  input  1  asynchronous active-low reset.
- clk  input  1  single clock; all state is in this domain.
- irq_raw_i  input  NUM_SRC  raw asynchronous interrupt lines.
- polarity_i  input  NUM_SRC  1 = source is active-low (inverted after sync); quasi-static.
- filt_en_i  input  NUM_SRC  1 = debounce filter enabled for that source.
- filt_len_i  input  FILT_WIDTH  shared debounce threshold in cycles; 0 is treated as 1.
- glitch_clr_i  input  NUM_SRC  clears the corresponding sticky glitch flag.
- irq_src_o  output  NUM_SRC  conditioned level, active-high; drives PLIC irq_src_i.
- irq_rise_o  output  NUM_SRC  one-cycle pulse when irq_src_o[i] goes 0->1.
- glitch_o  output  NUM_SRC  sticky flag: a rejected excursion occurred.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low. Every flop, including the synchronizer chain, resets to 0.
- Reset values: irq_src_o=0, irq_rise_o=0, glitch_o=0, all counters=0.
- Synchronizer: irq_raw_i[i] passes through SYNC_STAGES flops.
- Sample: s = sync_out XOR polarity_i[i]. Combinational; no extra register.
- Per-source state: stable (drives irq_src_o) and cnt[FILT_WIDTH].
- Effective threshold: L = (filt_en_i[i] == 0) ? 1 : max(filt_len_i, 1).
- Update rules per clk edge:
  - s != stable and cnt >= L-1: stable <= s, cnt <= 0.
  - s != stable and cnt < L-1: cnt <= cnt+1.
  - s == stable: cnt <= 0. If cnt != 0 this is a rejected glitch and glitch_o[i] is set.
- Use >= in the accept test, so lowering filt_len_i mid-count accepts on the next differing cycle. Raising it extends the wait.
- The counter never wraps: it is bounded by L-1 <= 2^FILT_WIDTH-2.
- Latency from a stable raw change to irq_src_o is exactly SYNC_STAGES + L clk edges:
  - filter disabled: SYNC_STAGES+1;
  - SYNC_STAGES=2, L=5: 7.
- irq_rise_o[i] is registered: it equals 1 in exactly the cycle irq_src_o[i] first reads 1 (computed as stable_next & ~stable). Falling transitions give no pulse.
- glitch_o: set has priority over glitch_clr_i in the same cycle. Otherwise glitch_clr_i clears it on the next edge.
- Clearing filt_en_i mid-count: L becomes 1, so a pending difference is accepted on the next edge.
- Toggling polarity_i is treated as an ordinary input change and is filtered.
- Sources are fully independent; there are no cross-source interactions.
- Reset asserted mid-count: all state returns to 0 immediately (asynchronously). After reset release, a still-asserted active-high input re-appears after SYNC_STAGES+L edges.

Decomposition:
- Shared package (plic_defs): PLIC_SOURCE_COUNT, PLIC_IRQ_SYNC_STAGES, PLIC_IRQ_FILT_WIDTH constants.
- Sub-module plic_irq_filter: one source, covering sync chain, polarity, counter, stable, rise and glitch logic.
- Top: a generate loop instantiating NUM_SRC copies of plic_irq_filter, sharing filt_len_i.

Test Plan:
- Reset check: apply rst_n=0 with all irq_raw_i=1 -> all outputs 0; hold rst_n=0 for 5 cycles -> outputs stay 0.
- Filter disabled, SYNC_STAGES=2, source 3: raw 0->1 held -> irq_src_o[3]=1 exactly 3 edges later; irq_rise_o[3] high that cycle only; glitch_o[3]=0.
- filt_en=1, filt_len=5, source 0:
  - 3-cycle high pulse -> irq_src_o[0] stays 0 and glitch_o[0] sets;
  - 5-cycle-plus high -> irq_src_o[0]=1 7 edges after the raw edge.
- polarity_i[2]=1 with raw held 1, then raw drops to 0 -> irq_src_o[2] rises 3 edges later (filter off). Raw 0->1 -> output falls with no rise pulse.
- Glitch clear priority: glitch_clr_i[1]=1 in the same cycle a new glitch sets -> glitch_o[1] stays 1. Clear on a later quiet cycle -> glitch_o[1]=0 next edge.
- Threshold change: filt_len=10, count reaches 6, then filt_len set to 4 -> stable updates on the next edge. Separately, rst_n pulsed low mid-count -> all state back to 0.
